// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter + TX FIFO + sequencer feeding one UART shifter from NREQ byte sources.
// Define UART_TX_ARB_PRIO0_EN to give requester 0 fixed top priority over the round-robin ring.
module uart_tx_arbiter #(
  parameter int NREQ       = 2,
  parameter int FIFO_DEPTH = 8,
  parameter int AW         = 3
) (
  input  logic              HCLK,
  input  logic              HRESETn,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*8-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  input  logic              tx_busy,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic [AW:0]       fifo_level,
  output logic              fifo_full,
  output logic              fifo_empty
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [1:0] {IDLE, START, ACK, DRAIN} state_t;

  state_t          state_q, state_d;
  logic            ack_cnt_q, ack_cnt_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic [PW-1:0]   rr_q, rr_d;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]     level_q, level_d;
  logic [7:0]      mem_q [FIFO_DEPTH];

  logic            grant_vld;
  logic [PW-1:0]   grant_idx, cand;
  logic [NREQ-1:0] rr_cand;
  logic [7:0]      push_data;
  logic            push, pop;

  assign fifo_full  = (level_q == (AW+1)'(FIFO_DEPTH));
  assign fifo_empty = (level_q == '0);
  assign fifo_level = level_q;
  assign tx_data    = tx_data_q;

  // With priority enabled, requester 0 is pulled out of the ring and checked first.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = '0;
    cand      = '0;
    rr_cand   = req_valid;
`ifdef UART_TX_ARB_PRIO0_EN
    rr_cand[0] = 1'b0;
    if (req_valid[0]) grant_vld = 1'b1;
`else
`endif
    for (int k = 0; k < NREQ; k++) begin
      cand = PW'((int'(rr_q) + k) % NREQ);
      if (!grant_vld && rr_cand[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign push = grant_vld && !fifo_full;

  always_comb begin
    req_ready = '0;
    push_data = '0;
    if (push) req_ready[grant_idx] = 1'b1;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == PW'(i)) push_data = req_data[i*8 +: 8];
    end
  end

  assign rr_d     = push ? PW'((int'(grant_idx) + 1) % NREQ) : rr_q;
  assign pop      = (state_q == START) && !fifo_empty;
  assign wr_ptr_d = wr_ptr_q + AW'(push);
  assign rd_ptr_d = rd_ptr_q + AW'(pop);

  always_comb begin
    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase
  end

  // tx_data is loaded on the way into START so it is already valid during the tx_start pulse.
  always_comb begin
    state_d   = state_q;
    ack_cnt_d = ack_cnt_q;
    tx_data_d = tx_data_q;
    tx_start  = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !tx_busy) begin
          state_d   = START;
          tx_data_d = mem_q[rd_ptr_q];
        end
      end
      START: begin
        tx_start  = 1'b1;
        ack_cnt_d = 1'b0;
        state_d   = ACK;
      end
      ACK: begin
        if (tx_busy) state_d = DRAIN;
        else if (ack_cnt_q) state_d = IDLE;
        else ack_cnt_d = 1'b1;
      end
      DRAIN: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (push) mem_q[wr_ptr_q] <= push_data;
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q   <= IDLE;
      ack_cnt_q <= 1'b0;
      tx_data_q <= 8'h00;
      rr_q      <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
    end else begin
      state_q   <= state_d;
      ack_cnt_q <= ack_cnt_d;
      tx_data_q <= tx_data_d;
      rr_q      <= rr_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: queue-based reference model plus a simple transmitter model driving tx_busy.
module tb_uart_tx_arbiter;
  localparam int NREQ  = 2;
  localparam int DEPTH = 8;
  localparam int AW    = 3;

  logic              HCLK = 1'b0;
  logic              HRESETn;
  logic [NREQ-1:0]   req_valid;
  logic [NREQ*8-1:0] req_data;
  logic [NREQ-1:0]   req_ready;
  logic              tx_busy;
  logic              tx_start;
  logic [7:0]        tx_data;
  logic [AW:0]       fifo_level;
  logic              fifo_full;
  logic              fifo_empty;

  uart_tx_arbiter #(.NREQ(NREQ), .FIFO_DEPTH(DEPTH), .AW(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn),
    .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
    .tx_busy(tx_busy), .tx_start(tx_start), .tx_data(tx_data),
    .fifo_level(fifo_level), .fifo_full(fifo_full), .fifo_empty(fifo_empty)
  );

  always #5 HCLK = ~HCLK;

  int errors = 0;
  int checks = 0;

  logic [7:0] exp_q[$];
  int rr_m, level_m, cyc, last_start, last_push, starts, idle_cnt, busy_cnt, frame_max;
  int gcnt[NREQ];
  bit auto_tx;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Grant rule: first valid requester at or after the round-robin pointer, wrapping.
  function automatic int model_grant(input logic [NREQ-1:0] v, input int rr);
`ifdef UART_TX_ARB_PRIO0_EN
    if (v[0]) return 0;
    for (int k = 0; k < NREQ; k++) begin
      int j = (rr + k) % NREQ;
      if (j != 0 && v[j]) return j;
    end
`else
    for (int k = 0; k < NREQ; k++) begin
      int j = (rr + k) % NREQ;
      if (v[j]) return j;
    end
`endif
    return -1;
  endfunction

  task automatic cycle();
    int g;
    bit st;
    logic [NREQ-1:0] er;
    @(negedge HCLK);
    g  = model_grant(req_valid, rr_m);
    er = '0;
    if (g >= 0 && level_m < DEPTH) er[g] = 1'b1;
    chk("req_ready", req_ready, er);
    chk("fifo_level", fifo_level, level_m);
    chk("fifo_full", fifo_full, level_m == DEPTH);
    chk("fifo_empty", fifo_empty, level_m == 0);
    st = tx_start;
    if (st) begin
      chk("start_nonempty", exp_q.size() != 0, 1);
      chk("start_gap", (cyc - last_start) >= 3, 1);
      if (auto_tx) chk("start_while_busy", tx_busy, 0);
      if (exp_q.size() != 0) begin
        chk("tx_data", tx_data, exp_q.pop_front());
        level_m--;
      end
      last_start = cyc;
      starts++;
      idle_cnt = 0;
    end else if (exp_q.size() != 0 && !tx_busy) begin
      idle_cnt++;
      if (idle_cnt > 8) begin
        chk("stall", idle_cnt, 8);
        idle_cnt = 0;
      end
    end else begin
      idle_cnt = 0;
    end
    if (er != 0) begin
      exp_q.push_back(req_data[g*8 +: 8]);
      level_m++;
      rr_m = (g + 1) % NREQ;
      last_push = cyc;
      gcnt[g]++;
    end
    @(posedge HCLK);
    #1;
    cyc++;
    if (auto_tx) begin
      if (st) busy_cnt = $urandom_range(frame_max, 0);
      tx_busy = (busy_cnt > 0);
      if (busy_cnt > 0) busy_cnt--;
    end
  endtask

  task automatic do_reset();
    @(posedge HCLK);
    #1;
    HRESETn = 1'b0;
    #2;
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_level", fifo_level, 0);
    chk("rst_empty", fifo_empty, 1);
    chk("rst_full", fifo_full, 0);
    exp_q.delete();
    level_m = 0; rr_m = 0; busy_cnt = 0; idle_cnt = 0;
    last_start = cyc - 100;
    @(posedge HCLK);
    #1;
    HRESETn = 1'b1;
    cyc++;
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int p, s0, prev, nstart;
    HRESETn = 1'b1; req_valid = '0; req_data = '0; tx_busy = 1'b0;
    auto_tx = 0; frame_max = 0; cyc = 0; starts = 0; last_push = -100;
    foreach (gcnt[i]) gcnt[i] = 0;
    do_reset();

    // single byte from requester 0, idle transmitter
    req_valid = 2'b01; req_data = {8'h00, 8'h41};
    p = cyc;
    cycle();
    chk("t1_accepted", last_push, p);
    req_valid = '0;
    repeat (4) cycle();
    chk("t1_latency", last_start - p, 2);
    chk("t1_starts", starts, 1);
    chk("t1_empty", fifo_empty, 1);

    // both requesters streaming into a blocked transmitter
    tx_busy = 1'b1;
    repeat (12) begin
      req_valid = 2'b11; req_data = NREQ*8'($urandom);
      cycle();
    end
    chk("t2_full", fifo_full, 1);
    chk("t2_ready_blocked", req_ready, 0);

    // one-cycle busy release while full
    s0 = starts;
    tx_busy = 1'b0;
    cycle();
    tx_busy = 1'b1;
    repeat (4) begin
      req_data = NREQ*8'($urandom);
      cycle();
    end
    chk("t3_one_pop", starts - s0, 1);
    chk("t3_refull", fifo_level, DEPTH);

    // transmitter never goes busy: ACK timeout path drains the FIFO
    req_valid = '0; auto_tx = 1; frame_max = 0; tx_busy = 1'b0;
    s0 = starts;
    repeat (50) begin
      prev = last_start; nstart = starts;
      cycle();
      if (starts != nstart && starts - s0 > 1) chk("t4_gap", last_start - prev, 4);
    end
    chk("t4_drained", fifo_empty, 1);
    chk("t4_count", starts - s0, DEPTH);

    // reset during DRAIN with bytes queued
    auto_tx = 0; tx_busy = 1'b1;
    repeat (6) begin
      req_valid = 2'b01; req_data = NREQ*8'($urandom);
      cycle();
    end
    req_valid = '0; tx_busy = 1'b0;
    cycle();
    tx_busy = 1'b1;
    repeat (3) cycle();
    chk("t5_level_before", fifo_level, 5);
    do_reset();
    tx_busy = 1'b0; auto_tx = 1; frame_max = 3;
    s0 = starts;
    req_valid = 2'b10; req_data = {8'hC1, 8'h00};
    cycle();
    req_data = {8'hC2, 8'h00};
    cycle();
    req_valid = '0;
    repeat (30) cycle();
    chk("t5_only_new", starts - s0, 2);
    chk("t5_empty", fifo_empty, 1);

    // both requesters always valid: grant pattern
    auto_tx = 0; tx_busy = 1'b1;
    foreach (gcnt[i]) gcnt[i] = 0;
    repeat (6) begin
      req_valid = 2'b11; req_data = NREQ*8'($urandom);
      cycle();
    end
`ifdef UART_TX_ARB_PRIO0_EN
    chk("t6_req0", gcnt[0], 6);
    chk("t6_req1", gcnt[1], 0);
`else
    chk("t6_req0", gcnt[0], 3);
    chk("t6_req1", gcnt[1], 3);
`endif
    req_valid = '0; tx_busy = 1'b0; auto_tx = 1; frame_max = 4;
    repeat (60) cycle();

    // random traffic against the model
    repeat (800) begin
      req_valid = NREQ'($urandom);
      req_data  = NREQ*8'($urandom);
      cycle();
    end
    req_valid = '0;
    repeat (150) cycle();
    chk("final_empty", fifo_empty, 1);
    chk("final_model_empty", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
